// File: rtl/ysyx_23060203_wbu.sv
// ysyx_23060203_wbu -- write-back / commit stage.
// Accepts one finished instruction per cycle from execute and owns the
// integer register file and the machine-mode CSR file. Commits GPR/CSR
// writes, performs ecall/mret/fence.i side effects and raises a registered
// one-cycle flush carrying the redirect PC. Decode reads GPRs and CSRs
// through combinational ports that bypass the write committing this cycle.
//
// Optional feature macro: WBU_HPM_EN
//   defined   -> 64-bit mcycle/minstret counters at 0xB00/0xB80/0xB02/0xB82
//   undefined -> those addresses read 0 and ignore writes
module ysyx_23060203_wbu #(
  parameter int          NR_GPR    = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  // commit interface from execute
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  // decode read ports
  input  logic [4:0]  gpr_raddr1,
  input  logic [4:0]  gpr_raddr2,
  output logic [31:0] gpr_rdata1,
  output logic [31:0] gpr_rdata2,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  // pipeline redirect
  output logic        flush,
  output logic [31:0] flush_pc
);

  localparam int AW = (NR_GPR > 1) ? $clog2(NR_GPR) : 1;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h015F_DEEB;
  localparam logic [31:0] ECALL_M_CAUSE = 32'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // ---------------------------------------------------------------------
  // Commit qualification
  // ---------------------------------------------------------------------
  logic commit;
  logic redirect;
  logic gpr_we;
  logic csr_we;

  // The slot following a flush is squashed; nothing commits under reset.
  assign commit   = in_valid & ~flush & reset;
  assign redirect = commit & (in_exc | in_ret | in_fencei);
  assign in_ready = 1'b1;

  // Destination register is real: nonzero and inside the implemented file.
  function automatic logic gpr_addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < 32'(NR_GPR));
  endfunction

  // Addresses that hold state and accept software writes.
  function automatic logic csr_writable(input logic [11:0] a);
    logic ok;
    ok = 1'b0;
    case (a)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: ok = 1'b1;
`ifdef WBU_HPM_EN
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign gpr_we = commit & gpr_addr_ok(in_gpr_waddr);
  assign csr_we = commit & in_csr_wen & csr_writable(in_csr_waddr);

  // ---------------------------------------------------------------------
  // GPR file
  // ---------------------------------------------------------------------
  logic [31:0] gpr [NR_GPR];

  // Register file: cleared on reset, written by committing instructions.
  // NOTE: the array is reset because software may read any register before
  // writing it; this forces flops rather than a RAM macro, which is the
  // intended implementation for a register file this small.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NR_GPR; i++) gpr[i] <= '0;
    end else if (gpr_we) begin
      gpr[in_gpr_waddr[AW-1:0]] <= in_gpr_wdata;
    end
  end

  // Decode read ports with write-through from the instruction committing now.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gpr_rdata1 = '0;
    gpr_rdata2 = '0;
    if (gpr_addr_ok(gpr_raddr1)) begin
      if (gpr_we && (in_gpr_waddr == gpr_raddr1)) gpr_rdata1 = in_gpr_wdata;
      else                                         gpr_rdata1 = gpr[gpr_raddr1[AW-1:0]];
    end
    if (gpr_addr_ok(gpr_raddr2)) begin
      if (gpr_we && (in_gpr_waddr == gpr_raddr2)) gpr_rdata2 = in_gpr_wdata;
      else                                         gpr_rdata2 = gpr[gpr_raddr2[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------
  // Machine-mode CSRs
  // ---------------------------------------------------------------------
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic [31:0] mstatus_nxt, mepc_nxt, mcause_nxt, mtvec_nxt;

  // Next CSR values: software write first, trap side effects override it.
  always_comb begin
    mstatus_nxt = mstatus;
    mtvec_nxt   = mtvec;
    mepc_nxt    = mepc;
    mcause_nxt  = mcause;
    if (csr_we) begin
      case (in_csr_waddr)
        CSR_MSTATUS: mstatus_nxt = in_csr_wdata;
        CSR_MTVEC:   mtvec_nxt   = in_csr_wdata;
        CSR_MEPC:    mepc_nxt    = in_csr_wdata;
        CSR_MCAUSE:  mcause_nxt  = in_csr_wdata;
        default: ;
      endcase
    end
    if (commit && in_exc) begin
      mepc_nxt                  = in_pc;
      mcause_nxt                = ECALL_M_CAUSE;
      mstatus_nxt[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_nxt[MSTATUS_MIE]  = 1'b0;
    end else if (commit && in_ret) begin
      mstatus_nxt[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_nxt[MSTATUS_MPIE] = 1'b1;
    end
  end

  // CSR state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement or process order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mstatus <= MSTATUS_RST;
      mtvec   <= MTVEC_RST;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      mstatus <= mstatus_nxt;
      mtvec   <= mtvec_nxt;
      mepc    <= mepc_nxt;
      mcause  <= mcause_nxt;
    end
  end

`ifdef WBU_HPM_EN
  // ---------------------------------------------------------------------
  // Hardware performance counters
  // ---------------------------------------------------------------------
  logic [63:0] mcycle, minstret;
  logic [63:0] mcycle_nxt, minstret_nxt;

  // Counters advance, then a software write to either half replaces that half.
  always_comb begin
    mcycle_nxt   = mcycle + 64'd1;
    minstret_nxt = minstret + {63'd0, commit};
    if (csr_we) begin
      case (in_csr_waddr)
        CSR_MCYCLE:    mcycle_nxt[31:0]    = in_csr_wdata;
        CSR_MCYCLEH:   mcycle_nxt[63:32]   = in_csr_wdata;
        CSR_MINSTRET:  minstret_nxt[31:0]  = in_csr_wdata;
        CSR_MINSTRETH: minstret_nxt[63:32] = in_csr_wdata;
        default: ;
      endcase
    end
  end

  // Counter registers; held at zero through reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
    end
  end
`endif

  // Decode CSR read port with write-through for a committing CSR write.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
      CSR_MARCHID:   csr_rdata = MARCHID_VAL;
`ifdef WBU_HPM_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:       csr_rdata = '0;
    endcase
    if (csr_we && (in_csr_waddr == csr_raddr)) csr_rdata = in_csr_wdata;
  end

  // ---------------------------------------------------------------------
  // Flush / redirect
  // ---------------------------------------------------------------------
  logic [31:0] redirect_pc;

  // Redirect target uses CSR values as they stood before this commit.
  always_comb begin
    redirect_pc = in_pc + 32'd4;
    if (in_exc)      redirect_pc = mtvec;
    else if (in_ret) redirect_pc = mepc;
  end

  // One-cycle flush pulse; the target is held between pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      flush <= redirect;
      if (redirect) flush_pc <= redirect_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// Self-checking bench for ysyx_23060203_wbu: a behavioural model of the
// architectural state (register array, named CSRs, counters, pending
// redirect) is advanced on each clock edge and compared against the DUT on
// every falling edge; directed sequences pin the model with literal values,
// then randomized traffic runs against it.
module tb_ysyx_23060203_wbu;

  logic        clock, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_csr_wen;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc, in_ret, in_fencei;
  logic [4:0]  gpr_raddr1, gpr_raddr2;
  logic [31:0] gpr_rdata1, gpr_rdata2;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        flush;
  logic [31:0] flush_pc;

  ysyx_23060203_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_ret(in_ret), .in_fencei(in_fencei),
    .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
    .gpr_rdata1(gpr_rdata1), .gpr_rdata2(gpr_rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_gpr [32];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_flush_pc;
  logic        m_flush;
  logic [63:0] m_mcycle, m_minstret;
  bit          model_live = 0;

  function automatic bit m_writable(input logic [11:0] a);
    if (a == 12'h300 || a == 12'h305 || a == 12'h341 || a == 12'h342) return 1;
`ifdef WBU_HPM_EN
    if (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015FDEEB;
`ifdef WBU_HPM_EN
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit commit_now();
    return in_valid && !m_flush && reset;
  endfunction

  function automatic logic [31:0] exp_gpr(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (commit_now() && in_gpr_waddr == a) return in_gpr_wdata;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] exp_csr(input logic [11:0] a);
    if (commit_now() && in_csr_wen && m_writable(in_csr_waddr) && in_csr_waddr == a)
      return in_csr_wdata;
    return m_csr(a);
  endfunction

  // Advance the model on each rising edge from the inputs presented before it.
  always @(posedge clock) begin
    logic [31:0] old_st, old_tvec, old_epc;
    bit          c, nf;
    logic [31:0] npc;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_mstatus = 32'h1800; m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
      m_flush = 0; m_flush_pc = 32'h0;
      m_mcycle = 64'h0; m_minstret = 64'h0;
      model_live = 1;
    end else begin
      c = in_valid && !m_flush;
      nf = 0; npc = m_flush_pc;
      old_st = m_mstatus; old_tvec = m_mtvec; old_epc = m_mepc;
      m_mcycle = m_mcycle + 1;
      if (c) m_minstret = m_minstret + 1;
      if (c) begin
        if (in_gpr_waddr != 0) m_gpr[in_gpr_waddr] = in_gpr_wdata;
        if (in_csr_wen) begin
          case (in_csr_waddr)
            12'h300: m_mstatus = in_csr_wdata;
            12'h305: m_mtvec   = in_csr_wdata;
            12'h341: m_mepc    = in_csr_wdata;
            12'h342: m_mcause  = in_csr_wdata;
`ifdef WBU_HPM_EN
            12'hB00: m_mcycle[31:0]    = in_csr_wdata;
            12'hB80: m_mcycle[63:32]   = in_csr_wdata;
            12'hB02: m_minstret[31:0]  = in_csr_wdata;
            12'hB82: m_minstret[63:32] = in_csr_wdata;
`endif
            default: ;
          endcase
        end
        if (in_exc) begin
          m_mepc = in_pc; m_mcause = 11;
          m_mstatus[7] = old_st[3]; m_mstatus[3] = 1'b0;
          nf = 1; npc = old_tvec;
        end else if (in_ret) begin
          m_mstatus[3] = old_st[7]; m_mstatus[7] = 1'b1;
          nf = 1; npc = old_epc;
        end else if (in_fencei) begin
          nf = 1; npc = in_pc + 32'd4;
        end
      end
      m_flush = nf; m_flush_pc = npc;
    end
  end

  // Compare every visible output against the model on each falling edge.
  always @(negedge clock) begin
    if (model_live) begin
      check("in_ready", 32'(in_ready), 32'h1);
      check("gpr_rdata1", gpr_rdata1, exp_gpr(gpr_raddr1));
      check("gpr_rdata2", gpr_rdata2, exp_gpr(gpr_raddr2));
      check("csr_rdata", csr_rdata, exp_csr(csr_raddr));
      check("flush", 32'(flush), 32'(m_flush));
      check("flush_pc", flush_pc, m_flush_pc);
    end
  end

  // ---------------- stimulus ----------------
  logic [11:0] csr_pool [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h340};

  task automatic idle();
    in_valid = 0; in_exc = 0; in_ret = 0; in_fencei = 0; in_csr_wen = 0;
    in_gpr_waddr = 0; in_gpr_wdata = 0; in_csr_waddr = 0; in_csr_wdata = 0; in_pc = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] exp_hpm;

  initial begin
    reset = 0; idle();
    gpr_raddr1 = 0; gpr_raddr2 = 0; csr_raddr = 12'h300;
    step();
    // fence.i presented while reset is held: discarded, no flush afterwards
    in_valid = 1; in_fencei = 1; in_pc = 32'h100; in_gpr_waddr = 3; in_gpr_wdata = 32'h55;
    step(); step();
    reset = 1; idle();
    step();
    check("no_flush_after_reset", 32'(flush), 32'h0);

    for (int i = 0; i < 32; i++) begin
      gpr_raddr1 = 5'(i);
      #1 check("gpr_reset", gpr_rdata1, 32'h0);
    end
    csr_raddr = 12'h300; #1 check("mstatus_reset", csr_rdata, 32'h1800);
    csr_raddr = 12'hF12; #1 check("marchid", csr_rdata, 32'h015FDEEB);
    csr_raddr = 12'hF11; #1 check("mvendorid", csr_rdata, 32'h79737978);
    csr_raddr = 12'h123; #1 check("csr_unimpl", csr_rdata, 32'h0);

    // x0 write is dropped
    step();
    in_valid = 1; in_gpr_waddr = 0; in_gpr_wdata = 32'hDEADBEEF; gpr_raddr1 = 0;
    step(); idle();
    #1 check("x0_write", gpr_rdata1, 32'h0);

    // bypass then stored value
    step();
    in_valid = 1; in_gpr_waddr = 5; in_gpr_wdata = 32'h12345678; gpr_raddr1 = 5;
    #1 check("x5_bypass", gpr_rdata1, 32'h12345678);
    step(); idle();
    #1 check("x5_stored", gpr_rdata1, 32'h12345678);

    // mtvec, then enable MIE
    in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'h305; in_csr_wdata = 32'h80000100;
    step();
    in_csr_waddr = 12'h300; in_csr_wdata = 32'h1808;
    step(); idle();

    // ecall; the slot right after is squashed
    in_valid = 1; in_exc = 1; in_pc = 32'h80000040;
    step(); idle();
    in_valid = 1; in_gpr_waddr = 7; in_gpr_wdata = 32'h77777777; gpr_raddr2 = 7;
    #1 check("ecall_flush", 32'(flush), 32'h1);
    check("ecall_flush_pc", flush_pc, 32'h80000100);
    check("squash_no_bypass", gpr_rdata2, 32'h0);
    step(); idle();
    #1 check("x7_squashed", gpr_rdata2, 32'h0);
    check("flush_one_cycle", 32'(flush), 32'h0);
    check("flush_pc_hold", flush_pc, 32'h80000100);
    csr_raddr = 12'h341; #1 check("mepc", csr_rdata, 32'h80000040);
    csr_raddr = 12'h342; #1 check("mcause", csr_rdata, 32'd11);
    csr_raddr = 12'h300; #1 check("mstatus_ecall", csr_rdata, 32'h1880);

    // mret
    step();
    in_valid = 1; in_ret = 1; in_pc = 32'h80000100;
    step(); idle();
    #1 check("mret_flush", 32'(flush), 32'h1);
    check("mret_flush_pc", flush_pc, 32'h80000040);
    check("mstatus_mret", csr_rdata, 32'h1888);
    step();

    // fence.i wraps
    in_valid = 1; in_fencei = 1; in_pc = 32'hFFFFFFFC;
    step(); idle();
    #1 check("fencei_flush", 32'(flush), 32'h1);
    check("fencei_flush_pc", flush_pc, 32'h0);
    step();

    // counters: 10 commits over 15 cycles from reset
    reset = 0; step(); reset = 1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 10); in_gpr_waddr = 5'(c + 1); in_gpr_wdata = $urandom;
      step();
    end
    idle();
`ifdef WBU_HPM_EN
    exp_hpm = 32'd10;
`else
    exp_hpm = 32'd0;
`endif
    csr_raddr = 12'hB02; #1 check("minstret", csr_rdata, exp_hpm);
`ifdef WBU_HPM_EN
    exp_hpm = 32'd15;
`endif
    csr_raddr = 12'hB00; #1 check("mcycle", csr_rdata, exp_hpm);
    step();
    in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'hB02; in_csr_wdata = 32'hFFFFFFFF;
    step(); idle();
    in_valid = 1;
    step(); idle();
`ifdef WBU_HPM_EN
    exp_hpm = 32'd1;
`else
    exp_hpm = 32'd0;
`endif
    csr_raddr = 12'hB82; #1 check("minstreth_carry", csr_rdata, exp_hpm);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kind;
      reset        = ($urandom_range(0, 49) != 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_pc        = $urandom;
      in_gpr_waddr = 5'($urandom);
      in_gpr_wdata = $urandom;
      kind         = $urandom_range(0, 11);
      in_exc       = (kind == 0);
      in_ret       = (kind == 1);
      in_fencei    = (kind == 2);
      in_csr_wen   = ($urandom_range(0, 2) == 0);
      in_csr_waddr = csr_pool[$urandom_range(0, 11)];
      in_csr_wdata = $urandom;
      if ((in_exc || in_ret) && in_csr_waddr == 12'h300) in_csr_wen = 0;
      gpr_raddr1   = ($urandom_range(0, 2) == 0) ? in_gpr_waddr : 5'($urandom);
      gpr_raddr2   = 5'($urandom);
      csr_raddr    = ($urandom_range(0, 2) == 0) ? in_csr_waddr : csr_pool[$urandom_range(0, 11)];
      step();
    end
    reset = 1; idle();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_wbu.md
Name: ysyx_23060203_wbu

Overview:
Write-back / commit stage, directly downstream of the execute stage. It accepts one finished instruction per cycle, and owns both the integer register file and the machine-mode CSR file. It commits GPR and CSR writes, handles ecall/mret/fence.i, and raises a one-cycle pipeline flush with the redirect PC. It also provides the combinational GPR and CSR read ports used by decode.

Parameters:
NR_GPR, 32, number of integer registers (16 for RV32E); write addresses >= NR_GPR are dropped, reads of them return 0
MTVEC_RST, 32'h0, reset value of mtvec

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset asserted)
in_valid  in  1  execute stage has a finished instruction
in_ready  out  1  always 1; this stage never back-pressures
in_pc  in  32  PC of the committing instruction
in_gpr_waddr  in  5  destination GPR; 0 = no write
in_gpr_wdata  in  32  GPR write data
in_csr_wen  in  1  CSR write enable
in_csr_waddr  in  12  CSR address
in_csr_wdata  in  32  CSR write data
in_exc  in  1  instruction is ecall
in_ret  in  1  instruction is mret
in_fencei  in  1  instruction is fence.i
gpr_raddr1, gpr_raddr2  in  5  decode read addresses
gpr_rdata1, gpr_rdata2  out  32  read data
csr_raddr  in  12  decode CSR read address
csr_rdata  out  32  CSR read data
flush  out  1  pipeline flush pulse, registered
flush_pc  out  32  redirect target, valid while flush=1

Behaviour:
- Commit handshake
  - Commit fires on in_valid & ~flush & reset; all state updates happen at that clock edge.
  - in_valid is ignored while flush=1 (squashed slot).
- GPR file
  - On commit with in_gpr_waddr != 0 and < NR_GPR: reg[waddr] <= in_gpr_wdata.
  - Reads are combinational. Address 0 or >= NR_GPR returns 0.
  - Write-through bypass: if a commit is firing and raddr == in_gpr_waddr != 0, return in_gpr_wdata.
- CSR file, all 32-bit
  - mstatus 0x300: reset 32'h1800.
  - mtvec 0x305: reset MTVEC_RST.
  - mepc 0x341: reset 0.
  - mcause 0x342: reset 0.
  - mvendorid 0xF11: constant 32'h79737978, read-only.
  - marchid 0xF12: constant 32'h015FDEEB, read-only.
  - Writes to read-only or unimplemented addresses are ignored; reads of unimplemented addresses return 0.
  - csr_rdata has the same write-through bypass as the GPR ports, for in_csr_wen commits to writable CSRs.
- ecall (in_exc) commit
  - mepc <= in_pc; mcause <= 11.
  - mstatus.MPIE(bit 7) <= MIE(bit 3); MIE <= 0.
  - Next cycle: flush=1, flush_pc = mtvec value at the commit edge.
  - Exception updates take priority over a simultaneous in_csr_wen to the same CSR.
- mret (in_ret) commit
  - MIE <= MPIE; MPIE <= 1.
  - Next cycle: flush=1, flush_pc = mepc value before the commit.
- fence.i commit: next cycle flush=1, flush_pc = in_pc + 4 (mod 2^32).
- Simultaneous exc/ret/fencei is illegal from upstream; priority is exc > ret > fencei.
- flush timing
  - flush is high exactly one cycle; it is never asserted on consecutive cycles, because the slot after a flush is squashed.
  - flush_pc holds its value when flush=0.
- Reset (reset=0)
  - GPRs cleared, CSRs to reset values, flush=0, flush_pc=0.
  - A commit presented during reset is discarded.
  - Reset deasserting with flush pending cancels the flush.

Optional Feature:
WBU_HPM_EN
- Defined: adds 64-bit counters.
  - mcycle: increments every non-reset cycle.
  - minstret: increments on every commit.
  - Readable and writable at 0xB00/0xB80 (mcycle low/high) and 0xB02/0xB82 (minstret low/high).
  - A CSR write to a counter half wins over the increment that cycle.
- Undefined: these addresses read 0 and writes are ignored.

Test Plan:
- Reset then read x0..x31 -> all 0; csr 0x300 -> 32'h1800; 0xF12 -> 32'h015FDEEB. Write x0 = 32'hDEADBEEF -> reads 0.
- Commit waddr=5, wdata=32'h12345678 while gpr_raddr1=5 -> gpr_rdata1=32'h12345678 in the same cycle (bypass), and again the next cycle (stored).
- Write mtvec=32'h80000100; then ecall at pc=32'h80000040 with mstatus.MIE=1 -> next cycle flush=1, flush_pc=32'h80000100; mepc=32'h80000040, mcause=11, mstatus=32'h1880.
- After the ecall, mret -> flush_pc=32'h80000040, mstatus MIE=1, MPIE=1. fence.i at pc=32'hFFFFFFFC -> flush_pc=32'h0.
- Assert in_valid in the cycle after an ecall (flush=1) with waddr=7 -> x7 unchanged. Assert reset=0 alongside a fencei commit -> no flush afterwards.
- With WBU_HPM_EN: 10 commits over 15 cycles from reset -> minstret=10, mcycle=15. Write 0xB02=32'hFFFFFFFF, then one commit -> 0xB82 increments by 1.
